// File: rtl/nic_pe_sequencer.sv
// PE-side sequencer for the cardinal NIC register port: TX poll+write and
// RX poll+read share the single port under round-robin arbitration.
module nic_pe_sequencer #(
  parameter int PAC_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 tx_valid,
  input  logic [0:PAC_WIDTH-1] tx_data,
  output logic                 tx_ready,
  output logic                 rx_valid,
  output logic [0:PAC_WIDTH-1] rx_data,
  input  logic                 rx_ready,
  input  logic                 stat_clr,
  output logic [15:0]          tx_stall_cnt,
  output logic [1:0]           nic_addr,
  output logic [0:PAC_WIDTH-1] nic_d_in,
  output logic                 nic_en,
  output logic                 nic_wr_en,
  input  logic [0:PAC_WIDTH-1] nic_d_out
);

  localparam logic [1:0] ADDR_IN_DATA  = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] ADDR_OUT_DATA = 2'b10;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_POLL,
    S_TX_WRITE,
    S_RX_POLL,
    S_RX_READ
  } state_t;

  typedef enum logic {
    GRANT_TX = 1'b0,
    GRANT_RX = 1'b1
  } grant_t;

  state_t               state_q, state_d;
  grant_t               last_grant_q, last_grant_d;
  logic                 rx_valid_q, rx_valid_d;
  logic [0:PAC_WIDTH-1] rx_data_q, rx_data_d;
  logic [15:0]          stall_q, stall_d;

  logic status_full;
  logic tx_elig;
  logic rx_elig;

  // Status words flag full/occupied in their last bit (LSB in [0:N-1] order).
  assign status_full = nic_d_out[PAC_WIDTH-1];
  assign tx_elig     = en && tx_valid;
  assign rx_elig     = en && (!rx_valid_q || rx_ready);

  // NOTE: every combinational output gets a default before the case, so no
  // path through the block leaves a variable unassigned and no latch appears.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      S_IDLE: begin
        if (tx_elig && (!rx_elig || last_grant_q == GRANT_RX)) begin
          state_d      = S_TX_POLL;
          last_grant_d = GRANT_TX;
        end else if (rx_elig) begin
          state_d      = S_RX_POLL;
          last_grant_d = GRANT_RX;
        end
      end
      S_TX_POLL:  state_d = status_full ? S_IDLE : S_TX_WRITE;
      S_TX_WRITE: state_d = S_IDLE;
      S_RX_POLL:  state_d = status_full ? S_RX_READ : S_IDLE;
      S_RX_READ:  state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // A capture on the RX_READ edge takes priority over a same-edge consume.
  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    stall_d    = stall_q;
    if (state_q == S_RX_READ) begin
      rx_valid_d = 1'b1;
      rx_data_d  = nic_d_out;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    if (stat_clr) begin
      stall_d = '0;
    end else if (state_q == S_TX_POLL && status_full && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // NIC pins are decoded from the state register alone, so reset forces them
  // to their idle values without a clock edge.
  always_comb begin
    nic_en    = 1'b0;
    nic_wr_en = 1'b0;
    nic_addr  = ADDR_IN_DATA;
    nic_d_in  = '0;
    tx_ready  = 1'b0;
    case (state_q)
      S_TX_POLL: begin
        nic_en   = 1'b1;
        nic_addr = ADDR_OUT_STAT;
      end
      S_TX_WRITE: begin
        nic_en    = 1'b1;
        nic_wr_en = 1'b1;
        nic_addr  = ADDR_OUT_DATA;
        nic_d_in  = tx_data;
        tx_ready  = 1'b1;
      end
      S_RX_POLL: begin
        nic_en   = 1'b1;
        nic_addr = ADDR_IN_STAT;
      end
      S_RX_READ: begin
        nic_en   = 1'b1;
        nic_addr = ADDR_IN_DATA;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= GRANT_RX;
      rx_valid_q   <= 1'b0;
      rx_data_q    <= '0;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rx_valid_q   <= rx_valid_d;
      rx_data_q    <= rx_data_d;
      stall_q      <= stall_d;
    end
  end

  assign rx_valid     = rx_valid_q;
  assign rx_data      = rx_data_q;
  assign tx_stall_cnt = stall_q;

endmodule

// File: tb/tb_nic_pe_sequencer.sv
// Self-checking bench for nic_pe_sequencer with a behavioural NIC register
// port model (input FIFO, output buffer with controllable full status).
module tb_nic_pe_sequencer;

  localparam int PW = 64;
  localparam int N_RAND = 100;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          tx_valid;
  logic [0:PW-1] tx_data;
  logic          tx_ready;
  logic          rx_valid;
  logic [0:PW-1] rx_data;
  logic          rx_ready;
  logic          stat_clr;
  logic [15:0]   tx_stall_cnt;
  logic [1:0]    nic_addr;
  logic [0:PW-1] nic_d_in;
  logic          nic_en;
  logic          nic_wr_en;
  logic [0:PW-1] nic_d_out;

  int checks = 0;
  int failures = 0;

  nic_pe_sequencer #(.PAC_WIDTH(PW)) dut (
    .clk(clk), .reset(reset), .en(en),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .stat_clr(stat_clr), .tx_stall_cnt(tx_stall_cnt),
    .nic_addr(nic_addr), .nic_d_in(nic_d_in), .nic_en(nic_en),
    .nic_wr_en(nic_wr_en), .nic_d_out(nic_d_out)
  );

  always #5 clk = ~clk;

  // NIC model: in_tail is pushed by the stimulus, in_head popped by the NIC.
  logic [0:PW-1] in_mem  [0:1023];
  logic [0:PW-1] out_log [0:1023];
  logic [9:0]    in_head = '0;
  logic [9:0]    in_tail = '0;
  logic [9:0]    out_cnt = '0;
  int            tx_polls = 0;
  int            full_polls = 0;
  int            full_until = 0;
  logic          in_nonempty;
  logic          out_full;

  assign in_nonempty = (in_tail != in_head);
  assign out_full    = (tx_polls < full_until);

  always_comb begin
    nic_d_out = '0;
    case (nic_addr)
      2'b00:   nic_d_out = in_nonempty ? in_mem[in_head] : '0;
      2'b01:   nic_d_out[PW-1] = in_nonempty;
      2'b11:   nic_d_out[PW-1] = out_full;
      default: ;
    endcase
  end

  always @(posedge clk) begin
    if (nic_en && nic_wr_en && nic_addr == 2'b10) begin
      out_log[out_cnt] <= nic_d_in;
      out_cnt <= out_cnt + 10'd1;
    end
    if (nic_en && !nic_wr_en && nic_addr == 2'b00 && in_nonempty)
      in_head <= in_head + 10'd1;
    if (nic_en && !nic_wr_en && nic_addr == 2'b11) begin
      tx_polls <= tx_polls + 1;
      if (out_full) full_polls <= full_polls + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic push_in(input logic [63:0] pkt);
    in_mem[in_tail] = pkt;
    in_tail = in_tail + 10'd1;
  endtask

  // Leaves the caller at a negedge with reset just released (IDLE cycle 0).
  task automatic do_reset();
    reset = 1'b0;
    en = 1'b0;
    tx_valid = 1'b0;
    tx_data = '0;
    rx_ready = 1'b0;
    stat_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_tail = in_head;
    full_until = tx_polls;
    reset = 1'b1;
  endtask

  task automatic wait_poll(input string name, input logic [1:0] addr);
    bit ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      nxt();
      if (nic_en && nic_addr == addr) ok = 1'b1;
    end
    check(name, 64'(ok), 64'd1);
  endtask

  task automatic wait_tx_ready(input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      nxt();
      if (tx_ready) ok = 1'b1;
    end
    check(name, 64'(ok), 64'd1);
  endtask

  typedef struct packed {
    logic       en;
    logic       tx_valid;
    logic       rx_ready;
    logic       e_nic_en;
    logic       e_wr_en;
    logic [1:0] e_addr;
    logic       e_tx_ready;
    logic       e_rx_valid;
  } vec_t;

  vec_t vecs [13];

  logic [63:0] sent_q[$];
  logic [63:0] pushed_q[$];
  logic [63:0] recv_q[$];

  initial begin
    logic [9:0] base;
    int cnt;
    int fp_base;
    int n_tx;
    int proto_err;
    bit drop_next;
    bit done;

    // en, tx_valid, rx_ready | nic_en, wr_en, addr, tx_ready, rx_valid
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0};

    reset = 1'b0;
    en = 1'b0;
    tx_valid = 1'b0;
    tx_data = '0;
    rx_ready = 1'b0;
    stat_clr = 1'b0;

    // Reset during TX_WRITE, then retry of the same packet.
    do_reset();
    en = 1'b1;
    tx_valid = 1'b1;
    tx_data = 64'hA5A5_0000_0000_0001;
    nxt();
    nxt();
    check("pre_rst_tx_ready", 64'(tx_ready), 64'd1);
    base = out_cnt;
    #1 reset = 1'b0;
    #1;
    check("rst_nic_en", 64'(nic_en), 64'd0);
    check("rst_tx_ready", 64'(tx_ready), 64'd0);
    check("rst_wr_en", 64'(nic_wr_en), 64'd0);
    check("rst_addr", 64'(nic_addr), 64'd0);
    check("rst_d_in", 64'(nic_d_in), 64'd0);
    check("rst_rx_valid", 64'(rx_valid), 64'd0);
    check("rst_rx_data", 64'(rx_data), 64'd0);
    check("rst_stall", 64'(tx_stall_cnt), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("retry_c0_tx_ready", 64'(tx_ready), 64'd0);
    nxt();
    check("retry_c1_tx_ready", 64'(tx_ready), 64'd0);
    check("retry_c1_addr", 64'(nic_addr), 64'd3);
    nxt();
    check("retry_c2_tx_ready", 64'(tx_ready), 64'd1);
    check("retry_c2_d_in", 64'(nic_d_in), 64'hA5A5_0000_0000_0001);
    nxt();
    tx_valid = 1'b0;
    repeat (8) nxt();
    check("retry_write_count", 64'(out_cnt - base), 64'd1);
    check("retry_write_data", 64'(out_log[base]), 64'hA5A5_0000_0000_0001);

    // TX backpressure: five full polls, then a single write.
    do_reset();
    en = 1'b1;
    full_until = tx_polls + 5;
    tx_valid = 1'b1;
    tx_data = 64'h0123_4567_89AB_CDEF;
    base = out_cnt;
    wait_tx_ready("bp_write_seen");
    check("bp_addr", 64'(nic_addr), 64'd2);
    check("bp_wr_en", 64'(nic_wr_en), 64'd1);
    check("bp_d_in", 64'(nic_d_in), 64'h0123_4567_89AB_CDEF);
    check("bp_stall_cnt", 64'(tx_stall_cnt), 64'd5);
    nxt();
    tx_valid = 1'b0;
    repeat (6) nxt();
    check("bp_write_count", 64'(out_cnt - base), 64'd1);

    // stat_clr on the same edge as a stall increment.
    full_until = tx_polls + 100;
    tx_valid = 1'b1;
    tx_data = 64'hFEED_0000_0000_0007;
    wait_poll("clr_poll_seen", 2'b11);
    stat_clr = 1'b1;
    nxt();
    stat_clr = 1'b0;
    check("clr_wins", 64'(tx_stall_cnt), 64'd0);
    wait_poll("clr_poll2_seen", 2'b11);
    nxt();
    check("stall_after_clr", 64'(tx_stall_cnt), 64'd1);
    full_until = tx_polls;
    wait_tx_ready("clr_write_seen");
    nxt();
    tx_valid = 1'b0;

    // RX drain with the PE not ready, then same-edge consume and grant.
    do_reset();
    push_in(64'hDEAD_BEEF_0000_0042);
    en = 1'b1;
    nxt();
    check("rx_poll_addr", 64'(nic_addr), 64'd1);
    check("rx_poll_en", 64'(nic_en), 64'd1);
    nxt();
    check("rx_read_addr", 64'(nic_addr), 64'd0);
    check("rx_read_en", 64'(nic_en), 64'd1);
    check("rx_read_valid", 64'(rx_valid), 64'd0);
    nxt();
    check("rx_valid_set", 64'(rx_valid), 64'd1);
    check("rx_data_cap", 64'(rx_data), 64'hDEAD_BEEF_0000_0042);
    push_in(64'hC0FF_EE00_0000_0099);
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (nic_en) cnt++;
      nxt();
    end
    check("rx_no_polls_held", 64'(cnt), 64'd0);
    rx_ready = 1'b1;
    nxt();
    rx_ready = 1'b0;
    check("same_edge_poll", 64'(nic_addr), 64'd1);
    check("same_edge_cleared", 64'(rx_valid), 64'd0);
    nxt();
    check("same_edge_read", 64'(nic_addr), 64'd0);
    nxt();
    check("same_edge_valid", 64'(rx_valid), 64'd1);
    check("same_edge_data", 64'(rx_data), 64'hC0FF_EE00_0000_0099);

    // Contention from reset, table-driven.
    do_reset();
    push_in(64'h1111_2222_3333_4444);
    tx_data = 64'h5555_6666_7777_8888;
    base = out_cnt;
    for (int i = 0; i < 13; i++) begin
      check($sformatf("tbl%0d_nic_en", i), 64'(nic_en), 64'(vecs[i].e_nic_en));
      check($sformatf("tbl%0d_wr_en", i), 64'(nic_wr_en), 64'(vecs[i].e_wr_en));
      check($sformatf("tbl%0d_addr", i), 64'(nic_addr), 64'(vecs[i].e_addr));
      check($sformatf("tbl%0d_tx_ready", i), 64'(tx_ready), 64'(vecs[i].e_tx_ready));
      check($sformatf("tbl%0d_rx_valid", i), 64'(rx_valid), 64'(vecs[i].e_rx_valid));
      en = vecs[i].en;
      tx_valid = vecs[i].tx_valid;
      rx_ready = vecs[i].rx_ready;
      nxt();
    end
    rx_ready = 1'b0;
    check("tbl_write_count", 64'(out_cnt - base), 64'd2);
    check("tbl_rx_data", 64'(rx_data), 64'h1111_2222_3333_4444);

    // en gating in IDLE, and en dropped during TX_POLL.
    do_reset();
    tx_valid = 1'b1;
    tx_data = 64'h0F0F_0F0F_0F0F_0F0F;
    base = out_cnt;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      nxt();
      if (nic_en) cnt++;
    end
    check("en0_idle", 64'(cnt), 64'd0);
    en = 1'b1;
    nxt();
    check("en_tx_poll", 64'(nic_addr), 64'd3);
    en = 1'b0;
    nxt();
    check("en_drop_write", 64'(tx_ready), 64'd1);
    nxt();
    tx_valid = 1'b0;
    check("en_drop_idle", 64'(nic_en), 64'd0);
    repeat (3) nxt();
    check("en_drop_stay_idle", 64'(nic_en), 64'd0);
    check("en_drop_count", 64'(out_cnt - base), 64'd1);

    // Randomised traffic against packet scoreboards.
    do_reset();
    en = 1'b1;
    base = out_cnt;
    nxt();
    fp_base = full_polls;
    n_tx = 0;
    proto_err = 0;
    drop_next = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 20000 && !done; c++) begin
      nxt();
      if (tx_ready && (!nic_wr_en || nic_addr != 2'b10)) proto_err++;
      if (tx_ready) begin
        sent_q.push_back(tx_data);
        drop_next = 1'b1;
      end else begin
        if (drop_next) begin
          tx_valid = 1'b0;
          drop_next = 1'b0;
        end
        if (!tx_valid && n_tx < N_RAND && $urandom_range(0, 3) == 0) begin
          tx_data = {$urandom, $urandom};
          tx_valid = 1'b1;
          n_tx++;
        end
      end
      rx_ready = 1'($urandom_range(0, 1));
      if (rx_valid && rx_ready) recv_q.push_back(rx_data);
      if (pushed_q.size() < N_RAND && $urandom_range(0, 2) == 0) begin
        pushed_q.push_back({$urandom, $urandom});
        push_in(pushed_q[pushed_q.size()-1]);
      end
      if ($urandom_range(0, 15) == 0) full_until = tx_polls + int'($urandom_range(1, 3));
      en = ($urandom_range(0, 9) != 0);
      done = (sent_q.size() == N_RAND) && (recv_q.size() == N_RAND);
    end
    check("rand_done", 64'(done), 64'd1);
    en = 1'b1;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    full_until = tx_polls;
    repeat (4) nxt();
    check("rand_proto", 64'(proto_err), 64'd0);
    check("rand_tx_count", 64'(out_cnt - base), 64'(sent_q.size()));
    for (int i = 0; i < sent_q.size(); i++)
      check($sformatf("rand_tx%0d", i), 64'(out_log[base + 10'(i)]), sent_q[i]);
    check("rand_rx_count", 64'(recv_q.size()), 64'(pushed_q.size()));
    for (int i = 0; i < recv_q.size() && i < pushed_q.size(); i++)
      check($sformatf("rand_rx%0d", i), recv_q[i], pushed_q[i]);
    check("rand_stall_cnt", 64'(tx_stall_cnt), 64'(full_polls - fp_base));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
